// File: rtl/mine_field_ctrl.sv
// Stateful minefield: LFSR-placed mines (one per row), pixel-collision detonation, one explosion slot.
// Define MINE_REARM_EN to re-arm the field with a fresh layout once every mine has been detonated.
module mine_field_ctrl #(
    parameter int          FIELD_X        = 64,
    parameter int          FIELD_Y        = 48,
    parameter int          ROWS           = 16,
    parameter int          COLS           = 12,
    parameter logic [7:0]  SEED           = 8'h5A,
    parameter int          EXPLODE_FRAMES = 32,
    parameter int          REARM_FRAMES   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       vsync,
    input  logic       tank1_gfx,
    input  logic       tank2_gfx,
    output logic       mine_gfx,
    output logic       explode_gfx,
    output logic       hit_p1,
    output logic       hit_p2,
    output logic [5:0] mines_left,
    output logic       field_ready
);

    localparam int             CB       = $clog2(COLS);
    localparam int             RB       = $clog2(ROWS);
    localparam logic [CB:0]    COLS_C   = (CB+1)'(COLS);
    localparam logic [RB-1:0]  LAST_ROW = RB'(ROWS-1);
    localparam logic [7:0]     EXP_LOAD = 8'(EXPLODE_FRAMES);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_EMPTY} state_t;

    state_t                    state_q;
    logic [RB-1:0]             r_q;
    logic [7:0]                lfsr_q;
    logic [ROWS-1:0][CB-1:0]   mine_col_q;
    logic [ROWS-1:0]           armed_q;
    logic [5:0]                mines_left_q;
    logic [7:0]                exp_cnt_q;
    logic [5:0]                exp_row_q;
    logic [5:0]                exp_col_q;
    logic                      hit_p1_q;
    logic                      hit_p2_q;
    logic                      vsync_q;

`ifdef MINE_REARM_EN
    localparam int             RW         = $clog2(REARM_FRAMES+1);
    localparam logic [RW-1:0]  REARM_LAST = RW'(REARM_FRAMES-1);
    logic [RW-1:0]             rearm_q;
`else
    logic                      unused_rearm;
    assign unused_rearm = |REARM_FRAMES;
`endif

    logic [8:0]    lx, ly;
    logic [5:0]    row, col;
    logic [RB-1:0] ri;
    logic          in_field, pat, hit1, hit2, hit, frame_tick;
    logic [7:0]    lfsr_d;
    logic [CB:0]   cand_w;
    logic [CB-1:0] cand_col;

    // Pixels left/above the field wrap to large values and fail the unsigned compare.
    assign lx       = hpos - 9'(FIELD_X);
    assign ly       = vpos - 9'(FIELD_Y);
    assign in_field = ({1'b0, lx} < 10'(COLS*8)) && ({1'b0, ly} < 10'(ROWS*8));
    assign row      = ly[8:3];
    assign col      = lx[8:3];
    assign ri       = row[RB-1:0];
    assign pat      = (~(lx[0] ^ lx[1]) ^ (ly[0] ^ ly[1])) & lx[2] & ly[2];

    assign mine_gfx    = (state_q == S_RUN) && in_field && (col == 6'(mine_col_q[ri]))
                         && armed_q[ri] && pat;
    assign explode_gfx = (exp_cnt_q != 8'd0) && in_field && (row == exp_row_q)
                         && (col == exp_col_q) && (exp_cnt_q[1] ^ lx[0] ^ ly[0]);

    assign hit1       = mine_gfx & tank1_gfx;
    assign hit2       = mine_gfx & tank2_gfx;
    assign hit        = hit1 | hit2;
    assign frame_tick = vsync & ~vsync_q;

    // Galois right-shift form of x^8+x^6+x^5+x^4+1.
    assign lfsr_d   = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    assign cand_w   = {1'b0, lfsr_q[CB-1:0]};
    assign cand_col = CB'((cand_w >= COLS_C) ? (cand_w - COLS_C) : cand_w);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT;
            r_q          <= '0;
            lfsr_q       <= SEED;
            mine_col_q   <= '0;
            armed_q      <= '0;
            mines_left_q <= '0;
            exp_cnt_q    <= '0;
            exp_row_q    <= '0;
            exp_col_q    <= '0;
            hit_p1_q     <= 1'b0;
            hit_p2_q     <= 1'b0;
            vsync_q      <= 1'b0;
`ifdef MINE_REARM_EN
            rearm_q      <= '0;
`endif
        end else begin
            vsync_q  <= vsync;
            hit_p1_q <= hit1;
            hit_p2_q <= hit2;

            // A fresh detonation takes the slot even on a frame tick.
            if (hit) begin
                exp_row_q <= row;
                exp_col_q <= col;
                exp_cnt_q <= EXP_LOAD;
            end else if (frame_tick && exp_cnt_q != 8'd0) begin
                exp_cnt_q <= exp_cnt_q - 8'd1;
            end

            case (state_q)
                S_INIT: begin
                    mine_col_q[r_q] <= cand_col;
                    armed_q[r_q]    <= 1'b1;
                    lfsr_q          <= lfsr_d;
                    r_q             <= r_q + RB'(1);
                    if (r_q == LAST_ROW) begin
                        state_q      <= S_RUN;
                        r_q          <= '0;
                        mines_left_q <= 6'(ROWS);
                    end
                end
                S_RUN: begin
                    if (hit) begin
                        armed_q[ri]  <= 1'b0;
                        mines_left_q <= mines_left_q - 6'd1;
                    end
`ifdef MINE_REARM_EN
                    if (mines_left_q == 6'd0) begin
                        state_q <= S_EMPTY;
                        rearm_q <= '0;
                    end
`endif
                end
`ifdef MINE_REARM_EN
                // LFSR is deliberately not reseeded so the next layout continues the sequence.
                S_EMPTY: begin
                    if (frame_tick) begin
                        if (rearm_q == REARM_LAST) begin
                            state_q <= S_INIT;
                            r_q     <= '0;
                        end else begin
                            rearm_q <= rearm_q + RW'(1);
                        end
                    end
                end
`endif
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign hit_p1      = hit_p1_q;
    assign hit_p2      = hit_p2_q;
    assign mines_left  = mines_left_q;
    assign field_ready = (state_q == S_RUN);

endmodule

// File: tb/tb_mine_field_ctrl.sv
// Bench for mine_field_ctrl: pixel-level behavioural model, per-cycle compare, directed + random stimulus.
module tb_mine_field_ctrl;
    localparam int ROWS = 16, COLS = 12, FX = 64, FY = 48, EXPF = 32, REARM = 60;
    localparam int M_INIT = 0, M_RUN = 1, M_EMPTY = 2;

    logic       clk = 1'b0, reset = 1'b1;
    logic [8:0] hpos = '0, vpos = '0;
    logic       vsync = 1'b0, tank1 = 1'b0, tank2 = 1'b0;
    logic       mine_gfx, explode_gfx, hit_p1, hit_p2, field_ready;
    logic [5:0] mines_left;

    always #5 clk = ~clk;

    mine_field_ctrl dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .vsync(vsync),
        .tank1_gfx(tank1), .tank2_gfx(tank2), .mine_gfx(mine_gfx), .explode_gfx(explode_gfx),
        .hit_p1(hit_p1), .hit_p2(hit_p2), .mines_left(mines_left), .field_ready(field_ready)
    );

    int vectors = 0, fails = 0;
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_mode, m_r, m_mines, m_ecnt, m_erow, m_ecol, m_rc;
    bit [7:0] m_lfsr;
    int       m_layout[ROWS];
    int       first_layout[ROWS];
    bit       m_armed[ROWS];
    bit       m_hp1, m_hp2, m_vsp;
    bit       chk_on = 1'b0;

    function automatic bit m_in(input int lx, input int ly);
        return lx >= 0 && lx < COLS*8 && ly >= 0 && ly < ROWS*8;
    endfunction

    function automatic bit m_pat(input int lx, input int ly);
        bit xa = (lx % 4 == 0) || (lx % 4 == 3);
        bit yb = (ly % 4 == 1) || (ly % 4 == 2);
        return (lx % 8 >= 4) && (ly % 8 >= 4) && (xa != yb);
    endfunction

    function automatic bit m_mine(input int h, input int v);
        int lx = h - FX, ly = v - FY;
        if (m_mode != M_RUN || !m_in(lx, ly)) return 1'b0;
        return m_armed[ly/8] && (m_layout[ly/8] == lx/8) && m_pat(lx, ly);
    endfunction

    function automatic bit m_expl(input int h, input int v);
        int lx = h - FX, ly = v - FY;
        if (m_ecnt == 0 || !m_in(lx, ly)) return 1'b0;
        return (ly/8 == m_erow) && (lx/8 == m_ecol) && ((((m_ecnt >> 1) ^ lx ^ ly) & 1) == 1);
    endfunction

    function automatic bit [7:0] lfsr_next(input bit [7:0] l);
        return (l >> 1) ^ ((l & 8'h01) != 0 ? 8'hB8 : 8'h00);
    endfunction

    function automatic int lfsr_col(input bit [7:0] l);
        int c = int'(l) % 16;
        return (c >= COLS) ? c - COLS : c;
    endfunction

    always @(posedge clk) begin : model
        bit h1, h2, tick, mh;
        int lx, ly;
        if (reset) begin
            m_mode = M_INIT; m_r = 0; m_lfsr = 8'h5A; m_mines = 0; m_ecnt = 0;
            m_hp1 = 0; m_hp2 = 0; m_vsp = 0; m_rc = 0;
            for (int i = 0; i < ROWS; i++) m_armed[i] = 0;
        end else begin
            lx = int'(hpos) - FX; ly = int'(vpos) - FY;
            mh = m_mine(int'(hpos), int'(vpos));
            h1 = mh && tank1; h2 = mh && tank2;
            tick = vsync && !m_vsp; m_vsp = vsync;
            if (h1 || h2) begin m_erow = ly/8; m_ecol = lx/8; m_ecnt = EXPF; end
            else if (tick && m_ecnt > 0) m_ecnt--;
            m_hp1 = h1; m_hp2 = h2;
            case (m_mode)
                M_INIT: begin
                    m_layout[m_r] = lfsr_col(m_lfsr);
                    m_armed[m_r] = 1;
                    m_lfsr = lfsr_next(m_lfsr);
                    m_r++;
                    if (m_r == ROWS) begin m_mode = M_RUN; m_mines = ROWS; end
                end
                M_RUN: begin
`ifdef MINE_REARM_EN
                    if (m_mines == 0) begin m_mode = M_EMPTY; m_rc = 0; end
`endif
                    if (h1 || h2) begin m_armed[ly/8] = 0; m_mines--; end
                end
                default: begin
                    if (tick) begin
                        m_rc++;
                        if (m_rc == REARM) begin m_mode = M_INIT; m_r = 0; end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("mine_gfx", int'(mine_gfx), int'(m_mine(int'(hpos), int'(vpos))));
            chk("explode_gfx", int'(explode_gfx), int'(m_expl(int'(hpos), int'(vpos))));
            chk("hit_p1", int'(hit_p1), int'(m_hp1));
            chk("hit_p2", int'(hit_p2), int'(m_hp2));
            chk("mines_left", int'(mines_left), m_mines);
            chk("field_ready", int'(field_ready), int'(m_mode == M_RUN));
        end
    end

    // ---------------- stimulus helpers ----------------
    bit s_mine, s_exp;
    task automatic cyc(input int h, input int v, input bit t1, input bit t2, input bit vs);
        hpos = 9'(h); vpos = 9'(v); tank1 = t1; tank2 = t2; vsync = vs;
        #2;
        s_mine = mine_gfx; s_exp = explode_gfx;
        @(posedge clk); #1;
    endtask

    task automatic rnd_cyc(input bit vs);
        cyc(int'($urandom_range(40, 180)), int'($urandom_range(30, 190)), 0, 0, vs);
    endtask

    // One 16-cycle frame; pixels wander around the given cell, or the whole field if row < 0.
    task automatic frame(input int row, input int col);
        for (int i = 0; i < 16; i++) begin
            if (row < 0) rnd_cyc(i < 4);
            else cyc(FX + col*8 + int'($urandom_range(0, 9)) - 1,
                     FY + row*8 + int'($urandom_range(0, 9)) - 1, 0, 0, i < 4);
        end
    endtask

    task automatic find_pix(input int row, output int h, output int v);
        h = -1; v = -1;
        for (int y = FY + row*8; y < FY + row*8 + 8 && h < 0; y++)
            for (int x = FX; x < FX + COLS*8 && h < 0; x++)
                if (m_mine(x, y)) begin h = x; v = y; end
    endtask

    task automatic cell_exp(input int row, input int col, output int n);
        n = 0;
        for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++) begin
                cyc(FX + col*8 + dx, FY + row*8 + dy, 0, 0, 0);
                n += int'(s_exp);
            end
    endtask

    task automatic detonate(input int row, input bit t1, input bit t2);
        int h, v;
        find_pix(row, h, v);
        chk($sformatf("find_row%0d", row), int'(h >= 0), 1);
        if (h >= 0) cyc(h, v, t1, t2, 0);
    endtask

    task automatic reinit();
        for (int i = 0; i < 16; i++) rnd_cyc(0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int lit, exp_lit, n, ml, h, v, diff, r3c, r7c, r9c;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 15; i++) rnd_cyc(0);
        chk("ready_after_15", int'(field_ready), 0);
        chk("mines_in_init", int'(mines_left), 0);
        rnd_cyc(0);
        chk("ready_after_16", int'(field_ready), 1);
        chk("mines_after_init", int'(mines_left), 16);

        // Hand-derived from seed 5A: 5A->2D->AE->57, low nibbles A,D,E,7.
        chk("model_col0", m_layout[0], 10);
        chk("model_col1", m_layout[1], 1);
        chk("model_col2", m_layout[2], 2);
        chk("model_col3", m_layout[3], 7);
        for (int i = 0; i < ROWS; i++) first_layout[i] = m_layout[i];

        hpos = 9'd148; vpos = 9'd52; #1;
        chk("row0_col10_lit", int'(mine_gfx), 1);

        // Raster sweep, no tanks.
        lit = 0; exp_lit = 0;
        for (int y = 40; y <= 180; y++)
            for (int x = 56; x <= 168; x++) begin
                exp_lit += int'(m_mine(x, y));
                cyc(x, y, 0, 0, 0);
                lit += int'(s_mine);
                if ((x == 63 || x == 160) && y >= 48 && y < 176)
                    chk($sformatf("edge_x%0d_y%0d", x, y), int'(s_mine), 0);
            end
        chk("sweep_lit_total", lit, exp_lit);
        chk("model_lit_total", exp_lit, 128);

        // Single detonation on row 3 by tank 1.
        r3c = m_layout[3];
        detonate(3, 1, 0);
        chk("row3_hit_p1", int'(hit_p1), 1);
        chk("row3_mines", int'(mines_left), 15);
        cyc(int'(hpos), int'(vpos), 0, 0, 0);
        chk("row3_hit_p1_drop", int'(hit_p1), 0);
        chk("row3_disarmed", int'(s_mine), 0);
        for (int f = 0; f < 31; f++) frame(3, r3c);
        cell_exp(3, r3c, n);
        chk("row3_exp_frame31", n, 32);
        frame(3, r3c);
        cell_exp(3, r3c, n);
        chk("row3_exp_frame32", n, 0);

        // Both tanks on the same pixel: one mine, two pulses.
        ml = int'(mines_left);
        detonate(5, 1, 1);
        chk("dual_hit_p1", int'(hit_p1), 1);
        chk("dual_hit_p2", int'(hit_p2), 1);
        chk("dual_mines", int'(mines_left), ml - 1);

        // Second detonation mid-explosion takes over the slot.
        r7c = m_layout[7]; r9c = m_layout[9];
        detonate(7, 1, 0);
        for (int f = 0; f < 12; f++) frame(7, r7c);
        chk("model_cnt_20", m_ecnt, 20);
        detonate(9, 0, 1);
        chk("second_hit_p2", int'(hit_p2), 1);
        chk("second_hit_p1", int'(hit_p1), 0);
        cell_exp(7, r7c, n);
        chk("old_cell_dark", n, 0);
        cell_exp(9, r9c, n);
        chk("new_cell_lit", n, 32);

        // Random play.
        for (int i = 0; i < 3000; i++)
            cyc(int'($urandom_range(56, 168)), int'($urandom_range(40, 180)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), (i % 50) < 5);

        // Reset mid-explosion.
        reset = 1'b1; reinit(); reset = 1'b0; reinit();
        chk("reinit_ready", int'(field_ready), 1);
        detonate(2, 1, 0);
        for (int f = 0; f < 3; f++) frame(2, m_layout[2]);
        reset = 1'b1;
        cyc(FX + m_layout[2]*8 + 1, FY + 16, 0, 0, 0);
        chk("rst_mine", int'(mine_gfx), 0);
        chk("rst_explode", int'(explode_gfx), 0);
        chk("rst_hit_p1", int'(hit_p1), 0);
        chk("rst_hit_p2", int'(hit_p2), 0);
        chk("rst_mines", int'(mines_left), 0);
        chk("rst_ready", int'(field_ready), 0);
        reset = 1'b0;
        reinit();
        chk("post_rst_mines", int'(mines_left), 16);

        // Detonate every mine.
        for (int y = FY; y < FY + ROWS*8; y++)
            for (int x = FX; x < FX + COLS*8; x++) cyc(x, y, 1, 0, 0);
        chk("all_gone", int'(mines_left), 0);
        cyc(FX, FY, 0, 0, 0); cyc(FX, FY, 0, 0, 0);

`ifdef MINE_REARM_EN
        chk("empty_not_ready", int'(field_ready), 0);
        for (int f = 0; f < REARM - 1; f++) frame(-1, 0);
        chk("empty_before_last", int'(field_ready), 0);
        frame(-1, 0);
        for (int i = 0; i < 20; i++) rnd_cyc(0);
        chk("rearm_ready", int'(field_ready), 1);
        chk("rearm_mines", int'(mines_left), 16);
        diff = 0;
        for (int i = 0; i < ROWS; i++) diff += int'(m_layout[i] != first_layout[i]);
        chk("rearm_layout_differs", int'(diff > 0), 1);
        for (int r = 0; r < ROWS; r++) begin
            find_pix(r, h, v);
            cyc(h, v, 0, 0, 0);
            chk($sformatf("rearm_row%0d_lit", r), int'(s_mine), 1);
        end
`else
        for (int f = 0; f < 70; f++) frame(-1, 0);
        chk("stay_run_ready", int'(field_ready), 1);
        chk("stay_run_mines", int'(mines_left), 0);
        diff = 0; h = 0; v = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
